// File: rtl/cache_assoc_if.sv
// Request/response bundle for cache_assoc: lookup port, write port and dirty-victim port.
// The cache sits on the slave side; the pipeline/memory side uses master.
interface cache_assoc_if #(
  parameter int NUM_SETS  = 32,
  parameter int NUM_WAYS  = 2,
  parameter int TAG_BITS  = 8,
  parameter int DATA_BITS = 64
);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic                 rd_en;
  logic [IDX_BITS-1:0]  rd_idx;
  logic [TAG_BITS-1:0]  rd_tag;
  logic                 rd_valid;
  logic [WAY_BITS-1:0]  rd_way;
  logic [DATA_BITS-1:0] rd_data;

  logic                 wr_en;
  logic                 wr_dirty;
  logic [IDX_BITS-1:0]  wr_idx;
  logic [TAG_BITS-1:0]  wr_tag;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;

  logic                 victim_valid;
  logic                 victim_ready;
  logic [IDX_BITS-1:0]  victim_idx;
  logic [TAG_BITS-1:0]  victim_tag;
  logic [DATA_BITS-1:0] victim_data;

  modport master (
    output rd_en, rd_idx, rd_tag,
    input  rd_valid, rd_way, rd_data,
    output wr_en, wr_dirty, wr_idx, wr_tag, wr_data,
    input  wr_ready,
    input  victim_valid, victim_idx, victim_tag, victim_data,
    output victim_ready
  );

  modport slave (
    input  rd_en, rd_idx, rd_tag,
    output rd_valid, rd_way, rd_data,
    input  wr_en, wr_dirty, wr_idx, wr_tag, wr_data,
    output wr_ready,
    output victim_valid, victim_idx, victim_tag, victim_data,
    input  victim_ready
  );
endinterface

// File: rtl/cache_assoc.sv
// N-way set-associative tag/data store with per-set true-LRU and a one-entry dirty-victim buffer.
// Define CACHE_WRITEBACK_EN for write-back (dirty bits + victim buffer); otherwise write-through.
module cache_assoc #(
  parameter int NUM_SETS  = 32,
  parameter int NUM_WAYS  = 2,
  parameter int TAG_BITS  = 8,
  parameter int DATA_BITS = 64
) (
  input logic         clock,
  input logic         reset,
  cache_assoc_if.slave bus
);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [WAY_BITS-1:0] LRU_AGE = WAY_BITS'(NUM_WAYS - 1);

  logic                 valid_q [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0]  age_q   [NUM_SETS][NUM_WAYS];

  logic                rd_hit;
  logic [WAY_BITS-1:0] rd_hit_way;
  logic [WAY_BITS-1:0] rd_age;
  logic                rd_touch;

  logic                wr_hit;
  logic                inv_found;
  logic [WAY_BITS-1:0] hit_way;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] lru_way;
  logic [WAY_BITS-1:0] wr_way;
  logic [WAY_BITS-1:0] wr_age;
  logic                wr_acc;

  always_comb begin
    rd_hit     = 1'b0;
    rd_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!rd_hit && valid_q[bus.rd_idx][w] && (tag_q[bus.rd_idx][w] == bus.rd_tag)) begin
        rd_hit     = 1'b1;
        rd_hit_way = WAY_BITS'(w);
      end
    end
  end

  assign bus.rd_valid = rd_hit;
  assign bus.rd_way   = rd_hit_way;
  assign bus.rd_data  = rd_hit ? data_q[bus.rd_idx][rd_hit_way] : '0;

  // Target priority: matching line, then lowest invalid way, then the LRU way.
  always_comb begin
    wr_hit    = 1'b0;
    inv_found = 1'b0;
    hit_way   = '0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!wr_hit && valid_q[bus.wr_idx][w] && (tag_q[bus.wr_idx][w] == bus.wr_tag)) begin
        wr_hit  = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!inv_found && !valid_q[bus.wr_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
      if (age_q[bus.wr_idx][w] == LRU_AGE) lru_way = WAY_BITS'(w);
    end
    wr_way = wr_hit ? hit_way : (inv_found ? inv_way : lru_way);
  end

  assign wr_age   = age_q[bus.wr_idx][wr_way];
  assign rd_age   = age_q[bus.rd_idx][rd_hit_way];
  assign wr_acc   = bus.wr_en && bus.wr_ready;
  // A write to the same set owns the MRU slot this edge.
  assign rd_touch = bus.rd_en && rd_hit && !(wr_acc && (bus.wr_idx == bus.rd_idx));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          age_q[s][w]   <= WAY_BITS'(w);
        end
      end
    end else begin
      if (rd_touch) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_BITS'(w) == rd_hit_way)
            age_q[bus.rd_idx][w] <= '0;
          else if (age_q[bus.rd_idx][w] < rd_age)
            age_q[bus.rd_idx][w] <= age_q[bus.rd_idx][w] + WAY_BITS'(1);
        end
      end
      if (wr_acc) begin
        valid_q[bus.wr_idx][wr_way] <= 1'b1;
        tag_q[bus.wr_idx][wr_way]   <= bus.wr_tag;
        data_q[bus.wr_idx][wr_way]  <= bus.wr_data;
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_BITS'(w) == wr_way)
            age_q[bus.wr_idx][w] <= '0;
          else if (age_q[bus.wr_idx][w] < wr_age)
            age_q[bus.wr_idx][w] <= age_q[bus.wr_idx][w] + WAY_BITS'(1);
        end
      end
    end
  end

`ifdef CACHE_WRITEBACK_EN
  logic                 dirty_q [NUM_SETS][NUM_WAYS];
  logic                 vic_valid_q;
  logic [IDX_BITS-1:0]  vic_idx_q;
  logic [TAG_BITS-1:0]  vic_tag_q;
  logic [DATA_BITS-1:0] vic_data_q;
  logic                 evict;

  // Only a miss-allocate over a valid dirty line produces a victim.
  assign evict = wr_acc && !wr_hit && valid_q[bus.wr_idx][wr_way] && dirty_q[bus.wr_idx][wr_way];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          dirty_q[s][w] <= 1'b0;
      vic_valid_q <= 1'b0;
      vic_idx_q   <= '0;
      vic_tag_q   <= '0;
      vic_data_q  <= '0;
    end else begin
      if (wr_acc)
        dirty_q[bus.wr_idx][wr_way] <= wr_hit ? (dirty_q[bus.wr_idx][wr_way] | bus.wr_dirty)
                                              : bus.wr_dirty;
      if (evict) begin
        vic_valid_q <= 1'b1;
        vic_idx_q   <= bus.wr_idx;
        vic_tag_q   <= tag_q[bus.wr_idx][wr_way];
        vic_data_q  <= data_q[bus.wr_idx][wr_way];
      end else if (vic_valid_q && bus.victim_ready) begin
        vic_valid_q <= 1'b0;
      end
    end
  end

  assign bus.wr_ready     = !vic_valid_q || bus.victim_ready;
  assign bus.victim_valid = vic_valid_q;
  assign bus.victim_idx   = vic_idx_q;
  assign bus.victim_tag   = vic_tag_q;
  assign bus.victim_data  = vic_data_q;
`else
  logic unused_wb_inputs;
  assign unused_wb_inputs = bus.wr_dirty ^ bus.victim_ready;

  assign bus.wr_ready     = 1'b1;
  assign bus.victim_valid = 1'b0;
  assign bus.victim_idx   = '0;
  assign bus.victim_tag   = '0;
  assign bus.victim_data  = '0;
`endif

endmodule
